// File: rtl/bpf_sweep_stim_if.sv
// Sample stream between the swept-sine generator and the DAC.
// The generator drives the master side; the DAC side is the slave.
interface bpf_sweep_stim_if #(
  parameter int OUT_W = 12
);
  logic                    sample_valid;
  logic                    sample_ready;
  logic signed [OUT_W-1:0] sample_data;

  modport master (output sample_valid, output sample_data, input sample_ready);
  modport slave  (input sample_valid, input sample_data, output sample_ready);
endinterface

// File: rtl/bpf_sweep_stim.sv
// Swept-sine stimulus generator: phase accumulator plus quarter-wave sine LUT, stepped by a sweep FSM.
// Optional phase dither is enabled by defining BPF_STIM_DITHER_EN (default build: plain truncation).
module bpf_sweep_stim #(
  parameter int PHASE_W = 24,
  parameter int OUT_W   = 12,
  parameter int LUT_AW  = 8,
  parameter int DWELL_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               abort,
  input  logic [PHASE_W-1:0] f_start,
  input  logic [PHASE_W-1:0] f_step,
  input  logic [7:0]         n_steps,
  input  logic [DWELL_W-1:0] dwell,
  bpf_sweep_stim_if.master   smp,
  output logic [7:0]         step_idx,
  output logic               step_strobe,
  output logic               busy,
  output logic               done
);

  localparam int LUT_N = 2 ** LUT_AW;
  localparam int MAG_W = OUT_W - 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_PRIME,
    S_RUN,
    S_DONE
  } state_t;

  // Quarter-wave table sampled at bin centres, so no entry is exactly 0 or full scale twice.
  function automatic logic [MAG_W-1:0] lut_entry(input int i);
    real amp;
    real x;
    amp = 2.0 ** MAG_W - 1.0;
    x   = amp * $sin(3.14159265358979323846 * (real'(i) + 0.5) / (2.0 * real'(LUT_N)));
    return MAG_W'($rtoi(x + 0.5));
  endfunction

  logic [MAG_W-1:0] lut_rom [LUT_N];

  for (genvar g = 0; g < LUT_N; g++) begin : g_lut
    assign lut_rom[g] = lut_entry(g);
  end

  state_t               state_q, state_d;
  logic [PHASE_W-1:0]   phase_q, phase_d;
  logic [PHASE_W-1:0]   fcw_q, fcw_d;
  logic [PHASE_W-1:0]   f_step_q, f_step_d;
  logic [7:0]           n_steps_q, n_steps_d;
  logic [DWELL_W-1:0]   dwell_last_q, dwell_last_d;
  logic [DWELL_W-1:0]   dwell_cnt_q, dwell_cnt_d;
  logic [7:0]           step_idx_q, step_idx_d;
  logic signed [OUT_W-1:0] sample_data_q, sample_data_d;
  logic                 sample_valid_q, sample_valid_d;
  logic                 step_strobe_q, step_strobe_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;

`ifdef BPF_STIM_DITHER_EN
  localparam int FRAC_W = PHASE_W - 2 - LUT_AW;
  logic [15:0] lfsr_q, lfsr_d;

  function automatic logic [PHASE_W-1:0] dither_phase(input logic [PHASE_W-1:0] p);
    return p + PHASE_W'(lfsr_q[FRAC_W-1:0]);
  endfunction
`else
  function automatic logic [PHASE_W-1:0] dither_phase(input logic [PHASE_W-1:0] p);
    return p;
  endfunction
`endif

  // Odd quadrants walk the table backwards; the upper half-cycle is the negated first half.
  function automatic logic signed [OUT_W-1:0] sine_of(input logic [PHASE_W-1:0] p);
    logic [1:0]              quad;
    logic [LUT_AW-1:0]       addr;
    logic signed [OUT_W-1:0] val;
    quad = p[PHASE_W-1 -: 2];
    addr = p[PHASE_W-3 -: LUT_AW];
    if (quad[0]) addr = ~addr;
    val = $signed({1'b0, lut_rom[addr]});
    if (quad[1]) val = -val;
    return val;
  endfunction

  logic                 handshake;
  logic [PHASE_W-1:0]   phase_adv;

  always_comb begin
    state_d        = state_q;
    phase_d        = phase_q;
    fcw_d          = fcw_q;
    f_step_d       = f_step_q;
    n_steps_d      = n_steps_q;
    dwell_last_d   = dwell_last_q;
    dwell_cnt_d    = dwell_cnt_q;
    step_idx_d     = step_idx_q;
    sample_data_d  = sample_data_q;
    sample_valid_d = sample_valid_q;
    step_strobe_d  = 1'b0;
    done_d         = 1'b0;
`ifdef BPF_STIM_DITHER_EN
    lfsr_d         = lfsr_q;
`endif
    handshake      = sample_valid_q & smp.sample_ready;
    phase_adv      = phase_q + fcw_q;

    if (abort) begin
      state_d        = S_IDLE;
      phase_d        = '0;
      fcw_d          = '0;
      dwell_cnt_d    = '0;
      step_idx_d     = '0;
      sample_data_d  = '0;
      sample_valid_d = 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (start) state_d = S_LOAD;
        end
        S_LOAD: begin
          f_step_d     = f_step;
          n_steps_d    = n_steps;
          dwell_last_d = (dwell == '0) ? '0 : dwell - DWELL_W'(1);
          phase_d      = '0;
          fcw_d        = f_start;
          dwell_cnt_d  = '0;
          step_idx_d   = '0;
`ifdef BPF_STIM_DITHER_EN
          lfsr_d       = 16'hACE1;
`endif
          state_d      = S_PRIME;
        end
        S_PRIME: begin
          sample_data_d  = sine_of(dither_phase(phase_q));
          sample_valid_d = 1'b1;
          state_d        = S_RUN;
        end
        S_RUN: begin
          if (handshake) begin
            phase_d       = phase_adv;
            sample_data_d = sine_of(dither_phase(phase_adv));
`ifdef BPF_STIM_DITHER_EN
            lfsr_d        = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
`endif
            if (dwell_cnt_q == dwell_last_q) begin
              if (step_idx_q == n_steps_q) begin
                sample_valid_d = 1'b0;
                done_d         = 1'b1;
                state_d        = S_DONE;
              end else begin
                fcw_d         = fcw_q + f_step_q;
                step_idx_d    = step_idx_q + 8'd1;
                dwell_cnt_d   = '0;
                step_strobe_d = 1'b1;
              end
            end else begin
              dwell_cnt_d = dwell_cnt_q + DWELL_W'(1);
            end
          end
        end
        S_DONE: begin
          state_d = S_IDLE;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= S_IDLE;
      phase_q        <= '0;
      fcw_q          <= '0;
      f_step_q       <= '0;
      n_steps_q      <= '0;
      dwell_last_q   <= '0;
      dwell_cnt_q    <= '0;
      step_idx_q     <= '0;
      sample_data_q  <= '0;
      sample_valid_q <= 1'b0;
      step_strobe_q  <= 1'b0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      phase_q        <= phase_d;
      fcw_q          <= fcw_d;
      f_step_q       <= f_step_d;
      n_steps_q      <= n_steps_d;
      dwell_last_q   <= dwell_last_d;
      dwell_cnt_q    <= dwell_cnt_d;
      step_idx_q     <= step_idx_d;
      sample_data_q  <= sample_data_d;
      sample_valid_q <= sample_valid_d;
      step_strobe_q  <= step_strobe_d;
      busy_q         <= busy_d;
      done_q         <= done_d;
    end
  end

`ifdef BPF_STIM_DITHER_EN
  always_ff @(posedge clk) begin
    if (rst) lfsr_q <= 16'hACE1;
    else     lfsr_q <= lfsr_d;
  end
`endif

  assign smp.sample_valid = sample_valid_q;
  assign smp.sample_data  = sample_data_q;
  assign step_idx         = step_idx_q;
  assign step_strobe      = step_strobe_q;
  assign busy             = busy_q;
  assign done             = done_q;

endmodule

// File: tb/tb_bpf_sweep_stim.sv
// Scoreboard bench for bpf_sweep_stim: a phase/sine reference model feeds an expected-sample queue
// that a free-running monitor drains on every accepted sample.
module tb_bpf_sweep_stim;

  localparam int PHASE_W = 24;
  localparam int OUT_W   = 12;
  localparam int LUT_AW  = 8;
  localparam int DWELL_W = 16;
  localparam real PI     = 3.14159265358979323846;

  logic               clk = 1'b0;
  logic               rst;
  logic               start;
  logic               abort;
  logic [PHASE_W-1:0] f_start;
  logic [PHASE_W-1:0] f_step;
  logic [7:0]         n_steps;
  logic [DWELL_W-1:0] dwell;
  logic [7:0]         step_idx;
  logic               step_strobe;
  logic               busy;
  logic               done;

  bpf_sweep_stim_if #(.OUT_W(OUT_W)) smp_if ();

  bpf_sweep_stim #(
    .PHASE_W(PHASE_W), .OUT_W(OUT_W), .LUT_AW(LUT_AW), .DWELL_W(DWELL_W)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .f_start(f_start), .f_step(f_step), .n_steps(n_steps), .dwell(dwell),
    .smp(smp_if), .step_idx(step_idx), .step_strobe(step_strobe),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic signed [OUT_W-1:0] data;
    logic [7:0]              idx;
    bit                      end_step;
    bit                      last;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  int   pops = 0;
  int   ready_mode = 0;
  bit   strobe_exp = 1'b0;
  bit   done_exp = 1'b0;
  bit   stall_prev = 1'b0;
  logic signed [OUT_W-1:0] stall_data;

  // Full-cycle sine evaluated at the centre of the truncated phase bin.
  function automatic logic signed [OUT_W-1:0] ref_sine(input logic [PHASE_W-1:0] p);
    real amp;
    real x;
    int  idx;
    int  r;
    amp = 2.0 ** (OUT_W - 1) - 1.0;
    idx = int'(p[PHASE_W-1 -: LUT_AW+2]);
    x   = amp * $sin(2.0 * PI * (real'(idx) + 0.5) / real'(2 ** (LUT_AW + 2)));
    if (x >= 0.0) r = $rtoi(x + 0.5);
    else          r = -$rtoi(-x + 0.5);
    return OUT_W'(r);
  endfunction

  task automatic checkOutput(input string name, input logic signed [31:0] actual,
                             input logic signed [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  initial begin
    smp_if.sample_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       smp_if.sample_ready = 1'b1;
        1:       smp_if.sample_ready = ~smp_if.sample_ready;
        default: smp_if.sample_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Monitor: every accepted sample is popped and compared; strobe/done must follow one cycle later.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      strobe_exp = 1'b0;
      done_exp   = 1'b0;
      stall_prev = 1'b0;
    end else begin
      checkOutput("step_strobe", 32'(step_strobe), 32'(strobe_exp));
      checkOutput("done", 32'(done), 32'(done_exp));
      if (stall_prev && smp_if.sample_valid)
        checkOutput("stall_hold", $signed(smp_if.sample_data), $signed(stall_data));
      strobe_exp = 1'b0;
      done_exp   = 1'b0;
      if (smp_if.sample_valid && smp_if.sample_ready && !abort) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_sample: got %0d, expected none", smp_if.sample_data);
        end else begin
          e = exp_q.pop_front();
          checkOutput("sample", $signed(smp_if.sample_data), $signed(e.data));
          checkOutput("step_idx", 32'(step_idx), 32'(e.idx));
          strobe_exp = e.end_step;
          done_exp   = e.last;
          pops++;
        end
      end
      stall_prev = smp_if.sample_valid && !smp_if.sample_ready && !abort;
      stall_data = smp_if.sample_data;
    end
  end

  task automatic applyStimulus(input logic [PHASE_W-1:0] fs, input logic [PHASE_W-1:0] fst,
                               input logic [7:0] n, input logic [DWELL_W-1:0] dw,
                               input int mode, input int abort_at);
    logic [PHASE_W-1:0] ph;
    logic [PHASE_W-1:0] fcw;
    exp_t e;
    int dw_eff;
    int total;
    int lat;
    int cyc;
    int base;
    ph     = '0;
    fcw    = fs;
    dw_eff = (dw == 0) ? 1 : int'(dw);
    total  = 0;
    for (int s = 0; s <= int'(n); s++) begin
      for (int d = 0; d < dw_eff; d++) begin
        e.data     = ref_sine(ph);
        e.idx      = 8'(s);
        e.end_step = (d == dw_eff - 1) && (s != int'(n));
        e.last     = (d == dw_eff - 1) && (s == int'(n));
        exp_q.push_back(e);
        ph = ph + fcw;
        total++;
      end
      fcw = fcw + fst;
    end

    base       = pops;
    ready_mode = mode;
    f_start    = fs;
    f_step     = fst;
    n_steps    = n;
    dwell      = dw;
    start      = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    lat   = 1;
    while (!smp_if.sample_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    checkOutput("latency", lat, 3);
    checkOutput("busy_run", 32'(busy), 1);

    if (abort_at > 0) begin
      cyc = 0;
      while (pops < base + abort_at && cyc < 200) begin
        @(posedge clk);
        #1;
        cyc++;
      end
      checkOutput("abort_reached", 32'(pops - base >= abort_at), 1);
      abort = 1'b1;
      @(posedge clk);
      #1;
      abort = 1'b0;
      checkOutput("abort_valid", 32'(smp_if.sample_valid), 0);
      checkOutput("abort_busy", 32'(busy), 0);
      checkOutput("abort_done", 32'(done), 0);
      checkOutput("abort_step_idx", 32'(step_idx), 0);
      checkOutput("abort_data", $signed(smp_if.sample_data), 0);
      exp_q.delete();
    end else begin
      cyc = 0;
      while (!done && cyc < 8 * total + 100) begin
        @(posedge clk);
        #1;
        cyc++;
      end
      if (!done) begin
        checks++;
        errors++;
        $display("[TB] FAIL done_timeout: got no done after %0d cycles, expected done", cyc);
      end else begin
        checkOutput("busy_in_done", 32'(busy), 1);
        @(posedge clk);
        #1;
        checkOutput("busy_after_done", 32'(busy), 0);
        checkOutput("valid_after_done", 32'(smp_if.sample_valid), 0);
      end
      checkOutput("queue_empty", exp_q.size(), 0);
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got no finish, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] r1;
    logic [31:0] r2;
    rst     = 1'b1;
    start   = 1'b0;
    abort   = 1'b0;
    f_start = '0;
    f_step  = '0;
    n_steps = '0;
    dwell   = '0;
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b0;
    checkOutput("rst_valid", 32'(smp_if.sample_valid), 0);
    checkOutput("rst_data", $signed(smp_if.sample_data), 0);
    checkOutput("rst_step_idx", 32'(step_idx), 0);
    checkOutput("rst_strobe", 32'(step_strobe), 0);
    checkOutput("rst_busy", 32'(busy), 0);
    checkOutput("rst_done", 32'(done), 0);

    applyStimulus(24'h400000, 24'h000000, 8'd0, 16'd0, 0, 0);
    applyStimulus(24'h400000, 24'h000000, 8'd0, 16'd4, 0, 0);
    applyStimulus(24'h400000, 24'h400000, 8'd2, 16'd2, 0, 0);
    applyStimulus(24'h400000, 24'h400000, 8'd2, 16'd2, 1, 0);
    applyStimulus(24'h400000, 24'h000000, 8'd0, 16'd8, 0, 3);
    applyStimulus(24'h400000, 24'h000000, 8'd0, 16'd4, 0, 0);
    applyStimulus(24'hFFFFFF, 24'h000002, 8'd1, 16'd3, 0, 0);

    for (int k = 0; k < 8; k++) begin
      r1 = $urandom;
      r2 = $urandom;
      applyStimulus(r1[PHASE_W-1:0], r2[PHASE_W-1:0], 8'($urandom_range(0, 4)),
                    16'($urandom_range(0, 6)), 2, 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bpf_sweep_stim.md
# bpf_sweep_stim

Digital swept-sine stimulus generator: the stage directly upstream of the analog AC bandpass filter under test, taking the place of its fixed 1 V / 1 kHz AC source. A phase accumulator with a quarter-wave sine LUT produces signed DAC samples over a valid/ready handshake. A sweep FSM steps the frequency control word through a programmed number of steps, holding each step for a programmed number of samples.

## Interface
- PHASE_W, 24, phase accumulator and frequency control word width
- OUT_W, 12, signed sample width; LUT amplitude is 2^(OUT_W-1)-1
- LUT_AW, 8, quarter-wave LUT address width (2^LUT_AW entries)
- DWELL_W, 16, dwell counter width
- clk  input  1  clock; all logic on rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  begin sweep; sampled only in IDLE
- abort  input  1  stop immediately; no done pulse
- f_start  input  PHASE_W  initial frequency control word
- f_step  input  PHASE_W  FCW increment per step (modulo 2^PHASE_W)
- n_steps  input  8  steps after the first; total steps = n_steps+1
- dwell  input  DWELL_W  samples per step; 0 treated as 1
- sample_valid  output  1  sample_data valid
- sample_ready  input  1  DAC accepts the sample
- sample_data  output  OUT_W  signed two's-complement sample
- step_idx  output  8  current step index
- step_strobe  output  1  one-cycle pulse on each frequency change
- busy  output  1  high in every state except IDLE
- done  output  1  one-cycle pulse at normal sweep completion

## Operation
- FSM states: IDLE, LOAD, PRIME, RUN, DONE.
- IDLE: start=1 -> LOAD. busy=0.
- LOAD: latch config; phase=0; fcw=f_start; dwell_cnt=0; step_idx=0 -> PRIME.
- PRIME: register LUT output for phase 0 into sample_data -> RUN.
- RUN: sample_valid=1.
  - Handshake (valid&ready): phase+=fcw; sample_data loads the LUT result for the new phase; dwell_cnt++.
  - Last dwell sample accepted and step_idx==n_steps -> DONE.
  - Last dwell sample accepted otherwise: fcw+=f_step; step_idx++; dwell_cnt=0; step_strobe=1.
  - Phase stays continuous across steps, with no reset at a step.
- DONE: done=1 for one cycle; sample_valid=0 -> IDLE.
- abort=1 in any state -> IDLE next cycle. sample_valid drops, no done, outputs return to reset values. abort has priority over start and over handshake.
- start while busy is ignored.
- Sine mapping:
  - Quadrant = phase[PHASE_W-1:PHASE_W-2]. addr = next LUT_AW bits.
  - addr is bit-inverted in quadrants 1 and 3. The value is negated in quadrants 2 and 3.
  - LUT[i] = round(A·sin(π/2·(i+0.5)/2^LUT_AW)), A=2^(OUT_W-1)-1. Negation never overflows.
- Arithmetic: phase and fcw additions wrap modulo 2^PHASE_W. Lower phase bits are truncated, or dithered (see Configuration).

## Timing
- Reset values: sample_valid=0, sample_data=0, step_idx=0, step_strobe=0, busy=0, done=0, state IDLE, phase=0, fcw=0.
- Latency: start sampled at edge T0 -> LOAD at T1 -> PRIME at T2 -> sample_valid=1 with the phase-0 sample at T3.
- Throughput: one sample per cycle while sample_ready is held high.
- While valid&!ready: sample_data, phase, and counters are frozen.
- step_strobe is asserted in the cycle after the handshake that ends a step, together with the updated step_idx.
- done is asserted the cycle after the final handshake. busy stays high through DONE and is low the following cycle.
- rst mid-sweep: same result as abort, and also clears the LFSR.

## Configuration
- BPF_STIM_DITHER_EN defined:
  - 16-bit Fibonacci LFSR, taps 16,14,13,11, seed 0xACE1 on rst and LOAD.
  - Steps once per handshake.
  - Its low (PHASE_W-2-LUT_AW) bits are added to the truncated phase bits before address extraction.
- BPF_STIM_DITHER_EN undefined: plain truncation, no LFSR logic. All test values below assume undefined.

## Test plan
- Quarter-rate tone, dwell=0: f_start=0x400000, n_steps=0, ready=1 -> single sample 6, then done one cycle later.
- Quarter-rate tone: f_start=0x400000, dwell=4, n_steps=0, ready=1 -> samples 6, 2047, -6, -2047, then done.
- Sweep: f_start=0x400000, f_step=0x400000, dwell=2, n_steps=2 -> step_strobe after samples 2 and 4; step_idx 0,1,2; 6 samples; one done pulse.
- Backpressure: toggle ready 1/0 per cycle -> sample_data stable whenever !ready; identical sample sequence to the ready=1 run.
- Abort: assert abort at sample 3 -> next cycle sample_valid=0, busy=0, no done. A subsequent start restarts from phase 0 with sample 6.
- FCW wrap: f_start=0xFFFFFF, f_step=0x000002 -> step-1 fcw=0x000001; phase wraps without glitch.
